// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of one MMIO slot. Each grant runs
// IDLE -> ACCESS (one slot strobe) -> ACK (one-cycle ack to the winner).
module mmio_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd_data,
  output logic          cs,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data,
  output logic [1:0]    dbg_state
);

  // Master handshake: req is held until the one-cycle ack; req/wr/addr/wr_data
  // are sampled only while IDLE, so masters may change them once granted.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_gnt;
  logic          r_last_grant;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wr_data;
  logic [DW-1:0] r_m0_rd_data;
  logic [DW-1:0] r_m1_rd_data;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic          r_cs;
  logic          r_read;
  logic          r_write;

  logic          w_any_req;
  logic          w_pick;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wr_data;

  // On a tie the master that did not win last time goes first.
  assign w_any_req     = m0_req | m1_req;
  assign w_pick        = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_sel_wr      = w_pick ? m1_wr      : m0_wr;
  assign w_sel_addr    = w_pick ? m1_addr    : m0_addr;
  assign w_sel_wr_data = w_pick ? m1_wr_data : m0_wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_m0_rd_data <= '0;
      r_m1_rd_data <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_cs         <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt     <= w_pick;
            r_wr      <= w_sel_wr;
            r_addr    <= w_sel_addr;
            r_wr_data <= w_sel_wr_data;
            r_cs      <= 1'b1;
            r_write   <= w_sel_wr;
            r_read    <= ~w_sel_wr;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_cs    <= 1'b0;
          r_read  <= 1'b0;
          r_write <= 1'b0;
          if (r_gnt) begin
            r_m1_rd_data <= r_wr ? '0 : rd_data;
            r_m1_ack     <= 1'b1;
          end else begin
            r_m0_rd_data <= r_wr ? '0 : rd_data;
            r_m0_ack     <= 1'b1;
          end
          r_state <= ACK;
        end
        ACK: begin
          r_m0_ack     <= 1'b0;
          r_m1_ack     <= 1'b0;
          r_last_grant <= r_gnt;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rd_data = r_m0_rd_data;
  assign m1_rd_data = r_m1_rd_data;
  assign cs         = r_cs;
  assign read       = r_read;
  assign write      = r_write;
  assign addr       = r_addr;
  assign wr_data    = r_wr_data;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: transaction-level timing model checked every cycle,
// plus directed scenarios with literal expectations and a small slot/GPO model.
module tb_mmio_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wr_data = '0;
  logic          m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wr_data = '0;
  logic          m0_ack, m1_ack, cs, read, write;
  logic [DW-1:0] m0_rd_data, m1_rd_data, wr_data, rd_data;
  logic [AW-1:0] addr;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  mmio_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
    .cs(cs), .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // ---------------- slot register file and GPO ----------------
  logic [DW-1:0] slot_mem [32];
  logic [7:0]    gpo_out;

  initial begin
    for (int i = 0; i < 32; i++) slot_mem[i] = 32'h1000_0000 + i;
    slot_mem[3] = 32'hDEAD_BEEF;
  end

  assign rd_data = slot_mem[addr];

  always @(posedge clk) if (cs && write) slot_mem[addr] <= wr_data;

  always @(posedge clk or posedge reset) begin
    if (reset) gpo_out <= 8'h00;
    else if (cs && write && addr == 5'd0) gpo_out <= wr_data[7:0];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A grant at edge k owns the slot for the cycle after k and is acked the
  // cycle after that; the next grant can happen no earlier than edge k+3.
  logic [DW-1:0] mem_model [32];
  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 32'h1000_0000 + i;
    mem_model[3] = 32'hDEAD_BEEF;
  end

  int            cyc, next_free, t_k;
  bit            have, last, t_m, t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd, t_res;
  logic          exp_cs, exp_rd_s, exp_wr_s, exp_ack0, exp_ack1;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_rd0, exp_rd1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; next_free = 0; have = 0; last = 1'b1; t_k = 0;
      exp_cs = 0; exp_rd_s = 0; exp_wr_s = 0; exp_ack0 = 0; exp_ack1 = 0;
      exp_addr = '0; exp_wd = '0; exp_rd0 = '0; exp_rd1 = '0;
    end else begin
      cyc++;
      if (cyc >= next_free && (m0_req || m1_req)) begin
        t_m       = (m0_req && m1_req) ? !last : m1_req;
        last      = t_m;
        have      = 1;
        t_k       = cyc;
        next_free = cyc + 3;
        t_wr      = t_m ? m1_wr : m0_wr;
        t_addr    = t_m ? m1_addr : m0_addr;
        t_wd      = t_m ? m1_wr_data : m0_wr_data;
        t_res     = t_wr ? '0 : mem_model[t_addr];
        if (t_wr) mem_model[t_addr] = t_wd;
      end
      exp_cs   = have && (cyc == t_k);
      exp_wr_s = exp_cs && t_wr;
      exp_rd_s = exp_cs && !t_wr;
      exp_ack0 = have && (cyc == t_k + 1) && !t_m;
      exp_ack1 = have && (cyc == t_k + 1) && t_m;
      if (have && cyc == t_k) begin
        exp_addr = t_addr;
        exp_wd   = t_wd;
      end
      if (have && cyc == t_k + 1) begin
        if (t_m) exp_rd1 = t_res;
        else     exp_rd0 = t_res;
      end
    end
  end

  // ---------------- per-cycle compare and monitor ----------------
  int   tcyc = 0;
  int   ack_q[$];
  int   ack_cyc[$];
  logic prev_cs = 1'b0;

  always @(negedge clk) begin
    tcyc++;
    chk("cs", cs, exp_cs);
    chk("read", read, exp_rd_s);
    chk("write", write, exp_wr_s);
    chk("addr", addr, exp_addr);
    chk("wr_data", wr_data, exp_wd);
    chk("m0_ack", m0_ack, exp_ack0);
    chk("m1_ack", m1_ack, exp_ack1);
    chk("m0_rd_data", m0_rd_data, exp_rd0);
    chk("m1_rd_data", m1_rd_data, exp_rd1);
    chk("ack_overlap", m0_ack & m1_ack, 0);
    chk("cs_back_to_back", prev_cs & cs, 0);
    prev_cs = cs;
    if (m0_ack) begin ack_q.push_back(0); ack_cyc.push_back(tcyc); end
    if (m1_ack) begin ack_q.push_back(1); ack_cyc.push_back(tcyc); end
  end

  // ---------------- driver tasks ----------------
  task automatic m_start(input bit m, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    if (m) begin m1_wr = wr; m1_addr = a; m1_wr_data = d; m1_req = 1'b1; end
    else   begin m0_wr = wr; m0_addr = a; m0_wr_data = d; m0_req = 1'b1; end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  int exp_order [4] = '{0, 1, 0, 1};
  int n_ack;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", cs, 0);
    chk("reset_acks", {m0_ack, m1_ack}, 0);
    chk("reset_m0_rd", m0_rd_data, 0);
    reset = 1'b0;
    step();

    // single write from master 0 to the GPO
    m_start(0, 1, 5'h00, 32'h0000_00A5);
    step();
    chk("wr_cs", cs, 1);
    chk("wr_write", write, 1);
    chk("wr_read", read, 0);
    chk("wr_addr", addr, 0);
    chk("wr_data_bus", wr_data, 32'h0000_00A5);
    step();
    chk("wr_ack", m0_ack, 1);
    chk("wr_cs_off", cs, 0);
    chk("wr_rd_zero", m0_rd_data, 0);
    m0_req = 1'b0;
    step();
    chk("gpo_out", gpo_out, 8'hA5);

    // single read from master 1
    m_start(1, 0, 5'h03, 32'h0);
    step();
    chk("rd_read", read, 1);
    chk("rd_addr", addr, 5'h03);
    step();
    chk("rd_ack", m1_ack, 1);
    chk("rd_data_m1", m1_rd_data, 32'hDEAD_BEEF);
    chk("rd_m0_untouched", m0_rd_data, 0);
    m1_req = 1'b0;
    step(); step();
    chk("rd_data_held", m1_rd_data, 32'hDEAD_BEEF);

    // reset mid-stream clears read data
    reset = 1'b1;
    step();
    chk("rst_m1_rd", m1_rd_data, 0);
    reset = 1'b0;

    // both masters hold req for 12 cycles: m0 first after reset, then alternate
    ack_q.delete(); ack_cyc.delete();
    @(posedge clk); #1;
    m0_wr = 0; m0_addr = 5'd1; m1_wr = 0; m1_addr = 5'd2;
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (12) step();
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) step();
    chk("rr_ack_count", ack_q.size(), 4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++) chk("rr_order", ack_q[i], exp_order[i]);
    for (int i = 1; i < ack_cyc.size(); i++) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

    // inputs changed while granted are ignored; held req repeats the transaction
    m_start(0, 1, 5'd7, 32'h0000_1234);
    step();
    m0_addr = 5'd9; m0_wr_data = 32'h0000_FFFF;
    #1;
    chk("iso_addr", addr, 5'd7);
    chk("iso_wr_data", wr_data, 32'h0000_1234);
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m0_ack) begin
        n_ack++;
        if (n_ack == 2) begin m0_req = 1'b0; break; end
      end
    end
    m0_req = 1'b0;
    chk("iso_two_acks", n_ack, 2);
    step();
    chk("iso_mem7", slot_mem[7], 32'h0000_1234);
    chk("iso_mem9", slot_mem[9], 32'h0000_FFFF);

    // reset during ACCESS: no ack, cs drops at once, m0 wins the next tie
    m_start(1, 0, 5'h03, 32'h0);
    step();
    chk("mid_cs_before", cs, 1);
    reset = 1'b1;
    m1_req = 1'b0;
    #1;
    chk("mid_cs_async", cs, 0);
    chk("mid_read_async", read, 0);
    ack_q.delete();
    step();
    reset = 1'b0;
    repeat (4) step();
    chk("mid_no_ack", ack_q.size(), 0);
    m0_wr = 1; m0_addr = 5'd10; m0_wr_data = 32'h0000_BEEF;
    m1_wr = 0; m1_addr = 5'd11;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 20 && ack_q.size() == 0; i++) step();
    m0_req = 1'b0; m1_req = 1'b0;
    chk("mid_first_ack_seen", ack_q.size() > 0, 1);
    if (ack_q.size() > 0) chk("mid_first_winner", ack_q[0], 0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter for the MMIO slot bus. It lets the processor bridge (master 0) and a secondary master such as a debug/UART bridge (master 1) share one slot interface (cs/read/write/addr/wr_data/rd_data) driving cores like the GPO. Each master issues one registered single-beat transaction at a time over a req/ack handshake. Ties are resolved round-robin, and the slot bus sees clean one-cycle accesses.

## Interface

- AW, 5, slot register address width (matches slot addr)
- DW, 32, data width (matches slot wr_data/rd_data)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 transaction request; held high until m0_ack
- m0_wr  in  1  master 0 direction: 1 = write, 0 = read
- m0_addr  in  AW  master 0 slot register address
- m0_wr_data  in  DW  master 0 write data
- m0_ack  out  1  one-cycle completion pulse to master 0
- m0_rd_data  out  DW  master 0 read result, valid with m0_ack, held until next m0_ack
- m1_req, m1_wr, m1_addr, m1_wr_data, m1_ack, m1_rd_data: same as m0_*, for master 1
- cs  out  1  slot chip select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  AW  slot register address
- wr_data  out  DW  slot write data
- rd_data  in  DW  slot read data, combinational from slot on addr

## Operation

- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Only one req high: grant that master.
  - Both high: grant the master that is not last_grant.
  - On grant: latch the granted master's wr/addr/wr_data into internal registers, record gnt, go to ACCESS.
- ACCESS, exactly 1 cycle:
  - cs=1, write=latched wr, read=~latched wr, addr/wr_data driven from latches.
  - For a read, capture rd_data into the granted master's rd_data register at the closing edge. For a write, load 0 into it.
  - Go to ACK.
- ACK, 1 cycle:
  - Granted master's ack=1; the other master's ack=0.
  - Update last_grant=gnt.
  - Go to IDLE.
- Slot outputs cs/read/write=0 outside ACCESS. addr and wr_data hold their latched values (don't-care to slots).
- Master req/wr/addr/wr_data are sampled only in IDLE. Changes during ACCESS/ACK have no effect.
- Req still high in IDLE after an ack is treated as a new transaction. Masters must drop req in the ack cycle to avoid a repeat.
- The non-granted master's rd_data register is never modified.
- Reset:
  - Asynchronous, from any state, including mid-ACCESS.
  - State goes to IDLE. All acks, cs, read, write go to 0. addr, wr_data, m0_rd_data, m1_rd_data go to 0.
  - last_grant goes to 1, so master 0 wins the first tie.
  - An in-flight transaction is dropped without ack. A write in ACCESS when reset asserts is not guaranteed to commit.

## Timing

- Req sampled high at edge k (FSM in IDLE):
  - ACCESS during cycle k..k+1, with cs high for exactly 1 cycle.
  - ACK during cycle k+1..k+2, with ack high for exactly 1 cycle.
- Latency from sampled req to ack is 2 cycles. The write commits in the slot at the edge ending ACCESS.
- Minimum transaction spacing is 3 cycles: IDLE, ACCESS, ACK.
- Both masters requesting continuously are served in alternation (m0, m1, m0, …), one grant per 3 cycles.
- Worst-case wait for a requesting master is one other transaction (3 cycles) before its own grant.
- All outputs are registered or decoded from the state register only. There is no combinational path from m*_req to slot outputs or acks.

## Test plan

- **Reset:** assert reset mid-stream → all outputs 0, state IDLE. Next m0 and m1 simultaneous req → m0 granted first.
- **Single write:** m0 write addr=5'h00, data=32'h0000_00A5 → cs=1, write=1, read=0, addr=0, wr_data=32'hA5 for exactly 1 cycle one edge after req. m0_ack pulses 1 cycle later. m0_rd_data=0. A GPO model shows data_out=8'hA5.
- **Single read:** m1 read addr=5'h03, slot model returns 32'hDEAD_BEEF → read=1 for 1 cycle. m1_ack pulses with m1_rd_data=32'hDEAD_BEEF, held after ack. m0_rd_data unchanged.
- **Simultaneous requests:** both masters hold req continuously for 12 cycles → grants alternate m0, m1, m0, m1. Acks are 3 cycles apart and never overlap. cs is never high in two consecutive cycles.
- **Sampling isolation:** m0 changes addr/data during ACCESS → the slot bus shows the values sampled in IDLE. A master keeping req high after ack gets a second transaction.
- **Reset mid-ACCESS:** assert reset during ACCESS → no ack is issued, cs drops asynchronously, and the FSM restarts in IDLE with last_grant=1.
